// File: rtl/approx_mul_seq_ctrl.sv
// rtl/approx_mul_seq_ctrl.sv - sequential 8x8 approximate multiplier, one row-pair per cycle
module approx_mul_seq_ctrl #(
    parameter int APPROX_COLS = 4,
    parameter bit EARLY_EXIT  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Columns below APPROX_COLS are dropped from every row-pair contribution.
    localparam logic [15:0] COL_MASK = 16'hFFFF << APPROX_COLS;

    state_t      state;
    state_t      state_next;
    logic [7:0]  x_reg;
    logic [7:0]  y_reg;
    logic [15:0] acc;
    logic [1:0]  k;

    logic [1:0]  pair_bits;
    logic [9:0]  row_sum;
    logic [15:0] contrib;
    logic [15:0] acc_next;
    logic        rem_zero;
    logic        accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign accept    = in_valid && in_ready;

    // Compressor slice: two partial-product rows for the current row-pair, shifted into place.
    always_comb begin
        pair_bits = x_reg[{k, 1'b0} +: 2];
        row_sum   = ({2'b00, y_reg} & {10{pair_bits[0]}})
                  + ({1'b0, y_reg, 1'b0} & {10{pair_bits[1]}});
        contrib   = ({6'b0, row_sum} << {k, 1'b0}) & COL_MASK;
        acc_next  = acc + contrib;
        rem_zero  = ((x_reg >> ({1'b0, k, 1'b0} + 4'd2)) == 8'd0);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: zero operands skip RUN; RUN ends after row-pair 3 or once no x bits remain.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (x == 8'd0 || y == 8'd0) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (k == 2'd3 || (EARLY_EXIT && rem_zero)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, accumulation, and product register loaded only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg   <= 8'd0;
            y_reg   <= 8'd0;
            acc     <= 16'd0;
            k       <= 2'd0;
            product <= 16'd0;
        end else if (accept) begin
            x_reg <= x;
            y_reg <= y;
            acc   <= 16'd0;
            k     <= 2'd0;
            if (x == 8'd0 || y == 8'd0) begin
                product <= 16'd0;
            end
        end else if (state == RUN) begin
            acc <= acc_next;
            k   <= k + 2'd1;
            if (state_next == DONE) begin
                product <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_approx_mul_seq_ctrl.sv
// tb/tb_approx_mul_seq_ctrl.sv - directed self-checking bench for approx_mul_seq_ctrl
module tb_approx_mul_seq_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        out_ready;
    logic        iv [3];
    logic        ir [3];
    logic        ov [3];
    logic        bz [3];
    logic [15:0] pr [3];

    int n_tests;
    int n_fail;

    // d0: truncating + early exit; d1: exact + early exit; d2: truncating, no early exit
    approx_mul_seq_ctrl #(.APPROX_COLS(4), .EARLY_EXIT(1'b1)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .x(x), .y(y),
        .out_valid(ov[0]), .out_ready(out_ready), .product(pr[0]), .busy(bz[0]));
    approx_mul_seq_ctrl #(.APPROX_COLS(0), .EARLY_EXIT(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .x(x), .y(y),
        .out_valid(ov[1]), .out_ready(out_ready), .product(pr[1]), .busy(bz[1]));
    approx_mul_seq_ctrl #(.APPROX_COLS(4), .EARLY_EXIT(1'b0)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .x(x), .y(y),
        .out_valid(ov[2]), .out_ready(out_ready), .product(pr[2]), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Accept one operand pair on DUT d, count RUN cycles and edges to out_valid
    // (accept edge included), check product, then drain the result.
    task automatic do_op(input int d, input logic [7:0] xv, input logic [7:0] yv,
                         input logic [15:0] exp_p, input int exp_busy);
        int edges;
        int busy_n;
        @(negedge clk);
        chk($sformatf("in_ready_before d%0d", d), ir[d], 1);
        x = xv;
        y = yv;
        iv[d] = 1'b1;
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        x = 8'hA5;
        y = 8'h5A;
        edges = 1;
        busy_n = 0;
        while (!ov[d] && edges < 20) begin
            if (bz[d]) busy_n++;
            @(posedge clk);
            #1;
            edges++;
        end
        chk($sformatf("out_valid d%0d x%0d y%0d", d, xv, yv), ov[d], 1);
        chk($sformatf("busy_cycles d%0d x%0d y%0d", d, xv, yv), busy_n, exp_busy);
        chk($sformatf("latency d%0d x%0d y%0d", d, xv, yv), edges, exp_busy + 1);
        chk($sformatf("product d%0d x%0d y%0d", d, xv, yv), pr[d], exp_p);
        chk($sformatf("in_ready_done d%0d", d), ir[d], 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk($sformatf("drained d%0d", d), ov[d], 0);
        chk($sformatf("in_ready_after d%0d", d), ir[d], 1);
        chk($sformatf("product_hold d%0d", d), pr[d], exp_p);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        x = 8'd0;
        y = 8'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst in_ready d%0d", i), ir[i], 1);
            chk($sformatf("rst out_valid d%0d", i), ov[i], 0);
            chk($sformatf("rst busy d%0d", i), bz[i], 0);
            chk($sformatf("rst product d%0d", i), pr[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // 65025 minus truncated 13 (row-pair 0) and 4 (row-pair 1)
        do_op(0, 8'd255, 8'd255, 16'd65008, 4);
        do_op(1, 8'd255, 8'd255, 16'd65025, 4);
        // 600 with low nibble cleared, single row-pair
        do_op(0, 8'd3, 8'd200, 16'd592, 1);
        do_op(2, 8'd3, 8'd200, 16'd592, 4);
        do_op(0, 8'd0, 8'd77, 16'd0, 0);
        do_op(0, 8'd77, 8'd0, 16'd0, 0);
        // exact 5*9, exits after row-pair 1
        do_op(1, 8'd5, 8'd9, 16'd45, 2);
        // only x[7] set: 2<<6 = 128, no truncation loss
        do_op(0, 8'd128, 8'd1, 16'd128, 4);

        // Backpressure: hold result in DONE with a competing in_valid
        @(negedge clk);
        x = 8'd3;
        y = 8'd200;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        x = 8'd255;
        y = 8'd255;
        for (int c = 0; c < 12 && !ov[0]; c++) begin
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp out_valid", ov[0], 1);
            chk("bp product", pr[0], 592);
            chk("bp in_ready", ir[0], 0);
        end
        @(negedge clk);
        iv[0] = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp release in_ready", ir[0], 1);
        chk("bp release out_valid", ov[0], 0);
        do_op(0, 8'd16, 8'd16, 16'd256, 3);

        // Asynchronous reset during row-pair 1
        @(negedge clk);
        x = 8'd255;
        y = 8'd255;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-reset busy", bz[0], 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid-run rst in_ready", ir[0], 1);
        chk("mid-run rst out_valid", ov[0], 0);
        chk("mid-run rst busy", bz[0], 0);
        chk("mid-run rst product", pr[0], 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("post-reset no out_valid", ov[0], 0);
        end
        do_op(0, 8'd16, 8'd16, 16'd256, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
